// File: rtl/loby_driver.sv
// loby_driver: replays one LoBy job (key + absorb/squeeze word stream) into the
// permutation core with fixed spacing and returns the dout seen after the last
// squeeze. Every output is a flop; strobes are derived from the next state.
module loby_driver #(
   parameter int unsigned KEY_W      = 257,
   parameter int unsigned DIN_W      = 64,
   parameter int unsigned INIT_GAP   = 1,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [KEY_W-1:0] job_key,
   input  logic             wd_valid,
   output logic             wd_ready,
   input  logic [DIN_W-1:0] wd_data,
   input  logic             wd_sqz,
   input  logic             wd_last,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [KEY_W-1:0] res_data,
   output logic [7:0]       res_sqz_cnt,
   output logic             busy,
   output logic             lb_init,
   output logic [KEY_W-1:0] lb_key,
   output logic [DIN_W-1:0] lb_din,
   output logic             lb_din_valid,
   output logic             lb_sqz,
   input  logic [KEY_W-1:0] lb_dout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_IGAP  = 3'd2;
   localparam logic [2:0] S_FETCH = 3'd3;
   localparam logic [2:0] S_ISSUE = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] IGAP_LAST = CNT_W'(INIT_GAP - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sqz_q, sqz_d;
   logic             last_q, last_d;
   logic             job_ready_q, job_ready_d;
   logic             wd_ready_q, wd_ready_d;
   logic             res_valid_q, res_valid_d;
   logic             busy_q, busy_d;
   logic             lb_init_q, lb_init_d;
   logic             lb_din_valid_q, lb_din_valid_d;
   logic             lb_sqz_q, lb_sqz_d;
   logic [KEY_W-1:0] lb_key_q, lb_key_d;
   logic [DIN_W-1:0] lb_din_q, lb_din_d;
   logic [KEY_W-1:0] res_data_q, res_data_d;
   logic [7:0]       res_sqz_cnt_q, res_sqz_cnt_d;

   // Next-state, datapath and registered-strobe computation.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      sqz_d          = sqz_q;
      last_d         = last_q;
      lb_key_d       = lb_key_q;
      lb_din_d       = lb_din_q;
      res_data_d     = res_data_q;
      res_sqz_cnt_d  = res_sqz_cnt_q;
      lb_din_valid_d = 1'b0;
      lb_sqz_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            // job_ready is a flop, so accept only when it was visible.
            if (job_valid && job_ready_q) begin
               state_d       = S_INIT;
               lb_key_d      = job_key;
               lb_din_d      = '0;
               res_data_d    = '0;
               res_sqz_cnt_d = '0;
               cnt_d         = '0;
            end
         end
         S_INIT: begin
            state_d = S_IGAP;
            cnt_d   = '0;
         end
         S_IGAP: begin
            if (cnt_q == IGAP_LAST) begin
               state_d = S_FETCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FETCH: begin
            // Load the pulse flops here so they are high during ISSUE.
            if (wd_valid && wd_ready_q) begin
               state_d        = S_ISSUE;
               lb_din_d       = wd_data;
               lb_din_valid_d = 1'b1;
               lb_sqz_d       = wd_sqz;
               sqz_d          = wd_sqz;
               last_d         = wd_last;
            end
         end
         S_ISSUE: begin
            state_d = S_GAP;
            cnt_d   = '0;
         end
         S_GAP: begin
            // Core updates dout on the edge that ends ISSUE; grab it one edge later.
            if (sqz_q && (cnt_q == '0)) begin
               res_data_d = lb_dout;
               if (res_sqz_cnt_q != 8'hFF) res_sqz_cnt_d = res_sqz_cnt_q + 8'd1;
            end
            if (cnt_q == GAP_LAST) begin
               state_d = last_q ? S_DONE : S_FETCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (res_ready && res_valid_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      lb_init_d   = (state_d == S_INIT);
      job_ready_d = (state_d == S_IDLE);
      wd_ready_d  = (state_d == S_FETCH);
      res_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and output registers; synchronous reset aborts any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         sqz_q          <= 1'b0;
         last_q         <= 1'b0;
         job_ready_q    <= 1'b0;
         wd_ready_q     <= 1'b0;
         res_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
         lb_init_q      <= 1'b0;
         lb_din_valid_q <= 1'b0;
         lb_sqz_q       <= 1'b0;
         lb_key_q       <= '0;
         lb_din_q       <= '0;
         res_data_q     <= '0;
         res_sqz_cnt_q  <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         sqz_q          <= sqz_d;
         last_q         <= last_d;
         job_ready_q    <= job_ready_d;
         wd_ready_q     <= wd_ready_d;
         res_valid_q    <= res_valid_d;
         busy_q         <= busy_d;
         lb_init_q      <= lb_init_d;
         lb_din_valid_q <= lb_din_valid_d;
         lb_sqz_q       <= lb_sqz_d;
         lb_key_q       <= lb_key_d;
         lb_din_q       <= lb_din_d;
         res_data_q     <= res_data_d;
         res_sqz_cnt_q  <= res_sqz_cnt_d;
      end
   end

   assign job_ready    = job_ready_q;
   assign wd_ready     = wd_ready_q;
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
   assign res_sqz_cnt  = res_sqz_cnt_q;
   assign busy         = busy_q;
   assign lb_init      = lb_init_q;
   assign lb_key       = lb_key_q;
   assign lb_din       = lb_din_q;
   assign lb_din_valid = lb_din_valid_q;
   assign lb_sqz       = lb_sqz_q;

endmodule

// File: tb/tb_loby_driver.sv
// Directed bench for loby_driver with a tiny core model: dout = base ^ squeezes seen.
module tb_loby_driver;
   localparam int KEY_W = 257;
   localparam int DIN_W = 64;
   localparam int INIT_GAP = 1;
   localparam int GAP_CYCLES = 2;
   localparam logic [KEY_W-1:0] DOUT_BASE = {1'b1, 64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF,
                                            64'hA5A5A5A55A5A5A5A, 64'hDEAD000000000000};
   localparam logic [KEY_W-1:0] KEY1 = {1'b1, 255'd0, 1'b1};
   localparam logic [KEY_W-1:0] KEY2 = {1'b0, 128'h0F0F_0F0F_1111_2222_3333_4444_5555_6666, 128'd7};

   logic clk = 1'b0, rst = 1'b1;
   logic job_valid = 1'b0, job_ready;
   logic [KEY_W-1:0] job_key = '0;
   logic wd_valid = 1'b0, wd_ready, wd_sqz = 1'b0, wd_last = 1'b0;
   logic [DIN_W-1:0] wd_data = '0;
   logic res_valid, res_ready = 1'b0, busy;
   logic [KEY_W-1:0] res_data, lb_key, lb_dout;
   logic [7:0] res_sqz_cnt;
   logic lb_init, lb_din_valid, lb_sqz;
   logic [DIN_W-1:0] lb_din;

   int checks = 0, errors = 0;
   int unsigned cyc = 0, sqz_seen = 0, ninit = 0, init_cyc = 0;
   int unsigned pulse_cyc[$];
   logic pulse_sqz[$];

   loby_driver #(.KEY_W(KEY_W), .DIN_W(DIN_W), .INIT_GAP(INIT_GAP), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_sqz(wd_sqz), .wd_last(wd_last),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sqz_cnt(res_sqz_cnt),
      .busy(busy), .lb_init(lb_init), .lb_key(lb_key), .lb_din(lb_din), .lb_din_valid(lb_din_valid),
      .lb_sqz(lb_sqz), .lb_dout(lb_dout));

   always #5 clk = ~clk;

   // Core model: dout advances on the edge that samples a squeeze pulse.
   assign lb_dout = DOUT_BASE ^ {225'd0, sqz_seen};

   // Strobe monitor: stamps every init and din_valid pulse with its cycle.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (lb_init) begin
         ninit <= ninit + 1;
         init_cyc <= cyc;
      end
      if (lb_din_valid) begin
         pulse_cyc.push_back(cyc);
         pulse_sqz.push_back(lb_sqz);
         if (lb_sqz) sqz_seen <= sqz_seen + 1;
      end
   end

   task automatic chk(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_job(input logic [KEY_W-1:0] key);
      int t = 0;
      job_valid = 1'b1;
      job_key = key;
      while (!job_ready && t < 50) begin step(1); t++; end
      if (t >= 50) chk("job_ready_timeout", '0, 257'd1);
      step(1);
      job_valid = 1'b0;
      chk("lb_init_after_accept", {256'd0, lb_init}, 257'd1);
      chk("lb_key_latched", lb_key, key);
   endtask

   task automatic send_word(input logic [DIN_W-1:0] d, input logic s, input logic l);
      int t = 0;
      while (!wd_ready && t < 50) begin step(1); t++; end
      if (t >= 50) chk("wd_ready_timeout", '0, 257'd1);
      wd_valid = 1'b1; wd_data = d; wd_sqz = s; wd_last = l;
      step(1);
      wd_valid = 1'b0; wd_sqz = 1'b0; wd_last = 1'b0;
   endtask

   task automatic wait_res();
      int t = 0;
      while (!res_valid && t < 50) begin step(1); t++; end
      if (t >= 50) chk("res_valid_timeout", '0, 257'd1);
   endtask

   task automatic finish_res();
      res_ready = 1'b1;
      step(1);
      res_ready = 1'b0;
      chk("res_valid_drop", {256'd0, res_valid}, 257'd0);
      chk("job_ready_after_done", {256'd0, job_ready}, 257'd1);
   endtask

   initial begin
      int unsigned s0, np0, n0;
      logic bad;

      // Reset state
      step(2);
      chk("rst_job_ready", {256'd0, job_ready}, 257'd0);
      chk("rst_busy", {256'd0, busy}, 257'd0);
      chk("rst_strobes", {254'd0, lb_init, lb_din_valid, lb_sqz}, 257'd0);
      chk("rst_res", {248'd0, res_valid, res_sqz_cnt}, 257'd0);
      rst = 1'b0;
      step(1);
      chk("job_ready_post_rst", {256'd0, job_ready}, 257'd1);

      // Job 1: two absorbs, two squeezes
      s0 = sqz_seen; np0 = pulse_cyc.size(); n0 = ninit;
      start_job(KEY1);
      chk("busy_in_job", {256'd0, busy}, 257'd1);
      chk("lb_din_zero_at_init", {193'd0, lb_din}, 257'd0);
      send_word(64'h0123456789ABCDEF, 1'b0, 1'b0);
      chk("issue_din_a0", {193'd0, lb_din}, {193'd0, 64'h0123456789ABCDEF});
      chk("issue_valid_a0", {255'd0, lb_din_valid, lb_sqz}, 257'd2);
      send_word(64'hFFFF0000FFFF0000, 1'b0, 1'b0);
      chk("issue_din_a1", {193'd0, lb_din}, {193'd0, 64'hFFFF0000FFFF0000});
      step(1);
      chk("din_hold_between", {193'd0, lb_din}, {193'd0, 64'hFFFF0000FFFF0000});
      chk("din_valid_single_cycle", {256'd0, lb_din_valid}, 257'd0);
      send_word(64'h0, 1'b1, 1'b0);
      chk("issue_valid_s0", {255'd0, lb_din_valid, lb_sqz}, 257'd3);
      send_word(64'h0, 1'b1, 1'b1);
      wait_res();
      chk("j1_sqz_cnt", {249'd0, res_sqz_cnt}, 257'd2);
      chk("j1_res_data", res_data, DOUT_BASE ^ {225'd0, s0 + 32'd2});
      chk("j1_init_pulses", 257'(ninit - n0), 257'd1);
      chk("j1_pulse_count", 257'(pulse_cyc.size() - np0), 257'd4);
      chk("j1_first_latency", 257'(pulse_cyc[np0] - init_cyc), 257'(2 + INIT_GAP));
      for (int i = 0; i < 3; i++)
         chk($sformatf("j1_spacing_%0d", i), 257'(pulse_cyc[np0+i+1] - pulse_cyc[np0+i]), 257'(2 + GAP_CYCLES));
      chk("j1_sqz_flags", {253'd0, pulse_sqz[np0], pulse_sqz[np0+1], pulse_sqz[np0+2], pulse_sqz[np0+3]}, 257'b0011);
      finish_res();
      chk("idle_busy", {256'd0, busy}, 257'd0);

      // Job 2: stall in FETCH, then hold result in DONE
      s0 = sqz_seen;
      start_job(KEY2);
      send_word(64'h1111, 1'b0, 1'b0);
      begin
         int t = 0;
         while (!wd_ready && t < 50) begin step(1); t++; end
      end
      bad = 1'b0; np0 = pulse_cyc.size();
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (lb_init || lb_din_valid || lb_sqz || !busy || !wd_ready) bad = 1'b1;
      end
      chk("stall_quiet", {256'd0, bad}, 257'd0);
      chk("stall_no_pulse", 257'(pulse_cyc.size() - np0), 257'd0);
      send_word(64'h2222, 1'b1, 1'b1);
      chk("resume_issue", {255'd0, lb_din_valid, lb_sqz}, 257'd3);
      wait_res();
      n0 = ninit; bad = 1'b0;
      job_valid = 1'b1; job_key = KEY1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (!res_valid || job_ready || res_sqz_cnt != 8'd1 ||
             res_data !== (DOUT_BASE ^ {225'd0, s0 + 32'd1})) bad = 1'b1;
      end
      chk("done_hold_stable", {256'd0, bad}, 257'd0);
      chk("done_job_ignored", 257'(ninit - n0), 257'd0);
      chk("done_key_kept", lb_key, KEY2);
      job_valid = 1'b0;
      finish_res();

      // Job 3: single absorb with last
      start_job(KEY1);
      chk("res_cleared_on_accept", res_data, '0);
      send_word(64'h3333, 1'b0, 1'b1);
      wait_res();
      chk("j3_res_data", res_data, '0);
      chk("j3_sqz_cnt", {249'd0, res_sqz_cnt}, 257'd0);
      finish_res();

      // Job 4: reset mid-job, then a clean job
      start_job(KEY2);
      send_word(64'h4444, 1'b0, 1'b0);
      send_word(64'h5555, 1'b1, 1'b0);
      step(2);
      rst = 1'b1;
      step(1);
      chk("midrst_strobes", {253'd0, lb_init, lb_din_valid, lb_sqz, busy}, 257'd0);
      chk("midrst_job_ready", {256'd0, job_ready}, 257'd0);
      rst = 1'b0;
      step(1);
      chk("midrst_job_ready_back", {256'd0, job_ready}, 257'd1);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (res_valid || busy || lb_din_valid) bad = 1'b1;
         step(1);
      end
      chk("midrst_no_result", {256'd0, bad}, 257'd0);
      s0 = sqz_seen;
      start_job(KEY1);
      send_word(64'h6666, 1'b1, 1'b1);
      wait_res();
      chk("post_rst_job_data", res_data, DOUT_BASE ^ {225'd0, s0 + 32'd1});
      chk("post_rst_job_cnt", {249'd0, res_sqz_cnt}, 257'd1);
      finish_res();

      // Job 5: 300 squeezes, counter saturates
      s0 = sqz_seen;
      start_job(KEY2);
      for (int i = 0; i < 300; i++) send_word(64'(i), 1'b1, (i == 299));
      wait_res();
      chk("sat_cnt", {249'd0, res_sqz_cnt}, 257'd255);
      chk("sat_res_data", res_data, DOUT_BASE ^ {225'd0, s0 + 32'd300});
      finish_res();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
